// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer: radix-2 shift-add multiply, restoring divide.
// Optional `MULDIV_FAST_MUL_EN` completes all multiply ops in a single cycle.
module muldiv_sequencer #(
    parameter int unsigned BITS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  logic [2:0]      req_op,
    input  logic [BITS-1:0] req_a,
    input  logic [BITS-1:0] req_b,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            resp_valid,
    output logic [BITS-1:0] resp_data
);
    localparam int unsigned CNT_W = (BITS > 1) ? $clog2(BITS) : 1;
    localparam logic [BITS-1:0] MIN_NEG = {1'b1, {(BITS-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t              r_state, w_next;
    logic [2:0]          r_op;
    logic [BITS-1:0]     r_a, r_b, r_resp_data;
    logic [2*BITS-1:0]   r_acc;
    logic [CNT_W-1:0]    r_count;
    logic                r_neg, r_rneg;

    logic                w_accept, w_a_signed, w_b_signed, w_sa, w_sb;
    logic                w_div_zero, w_div_ovf, w_special, w_fast;
    logic [BITS-1:0]     w_a_mag, w_b_mag, w_special_res, w_fast_res;
    logic [BITS:0]       w_mul_sum, w_rem_shift, w_diff;
    logic [2*BITS-1:0]   w_mul_next, w_div_next, w_acc_next;

    // acc holds a magnitude product ({hi,lo}) or {remainder, quotient}
    function automatic logic [BITS-1:0] f_select(input logic [2:0] op, input logic [2*BITS-1:0] acc,
                                                 input logic neg, input logic rneg);
        logic [2*BITS-1:0] prod;
        logic [BITS-1:0]   quo, rem;
        prod = neg ? -acc : acc;
        quo  = neg ? -acc[BITS-1:0] : acc[BITS-1:0];
        rem  = rneg ? -acc[2*BITS-1:BITS] : acc[2*BITS-1:BITS];
        if (op[2])
            return op[1] ? rem : quo;
        return (op[1:0] == 2'b00) ? prod[BITS-1:0] : prod[2*BITS-1:BITS];
    endfunction

    always_comb begin
        w_a_signed = 1'b0;
        w_b_signed = 1'b0;
        case (req_op)
            3'b000, 3'b001, 3'b100, 3'b110: begin w_a_signed = 1'b1; w_b_signed = 1'b1; end
            3'b010:                         w_a_signed = 1'b1;
            default: ;
        endcase
    end

    assign w_accept   = (r_state == S_IDLE) && req_valid && !flush;
    assign w_sa       = w_a_signed && req_a[BITS-1];
    assign w_sb       = w_b_signed && req_b[BITS-1];
    assign w_a_mag    = w_sa ? -req_a : req_a;
    assign w_b_mag    = w_sb ? -req_b : req_b;
    assign w_div_zero = req_op[2] && (req_b == '0);
    assign w_div_ovf  = req_op[2] && !req_op[0] && (req_a == MIN_NEG) && (req_b == '1);
    assign w_special  = w_div_zero || w_div_ovf;
    assign w_special_res = w_div_zero ? (req_op[1] ? req_a : '1) : (req_op[1] ? '0 : MIN_NEG);

`ifdef MULDIV_FAST_MUL_EN
    logic [2*BITS-1:0] w_fast_prod;
    assign w_fast_prod = {{BITS{1'b0}}, w_a_mag} * {{BITS{1'b0}}, w_b_mag};
    assign w_fast      = !req_op[2];
    assign w_fast_res  = f_select(req_op, w_fast_prod, w_sa ^ w_sb, w_sa);
`else
    assign w_fast      = 1'b0;
    assign w_fast_res  = '0;
`endif

    // one iteration step; low half of acc shifts out multiplier bits / in quotient bits
    assign w_mul_sum   = {1'b0, r_acc[2*BITS-1:BITS]} + (r_acc[0] ? {1'b0, r_a} : '0);
    assign w_mul_next  = {w_mul_sum, r_acc[BITS-1:1]};
    assign w_rem_shift = {r_acc[2*BITS-1:BITS], r_acc[BITS-1]};
    assign w_diff      = w_rem_shift - {1'b0, r_b};
    assign w_div_next  = {(w_diff[BITS] ? w_rem_shift[BITS-1:0] : w_diff[BITS-1:0]),
                          r_acc[BITS-2:0], ~w_diff[BITS]};
    assign w_acc_next  = r_op[2] ? w_div_next : w_mul_next;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        stall      = 1'b0;
        busy       = 1'b0;
        resp_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                stall = req_valid && !flush;
                if (w_accept) w_next = (w_special || w_fast) ? S_DONE : S_CALC;
            end
            S_CALC: begin
                stall = 1'b1;
                busy  = 1'b1;
                if (flush)              w_next = S_IDLE;
                else if (r_count == '0) w_next = S_DONE;
            end
            S_DONE: begin
                resp_valid = !flush;
                w_next     = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_count     <= '0;
            r_neg       <= 1'b0;
            r_rneg      <= 1'b0;
            r_resp_data <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_accept) begin
                r_op    <= req_op;
                r_a     <= w_a_mag;
                r_b     <= w_b_mag;
                r_neg   <= w_sa ^ w_sb;
                r_rneg  <= w_sa;
                r_count <= CNT_W'(BITS-1);
                r_acc   <= {{BITS{1'b0}}, (req_op[2] ? w_a_mag : w_b_mag)};
                if (w_special)   r_resp_data <= w_special_res;
                else if (w_fast) r_resp_data <= w_fast_res;
            end
        end else if (r_state == S_CALC && !flush) begin
            r_acc <= w_acc_next;
            if (r_count == '0) r_resp_data <= f_select(r_op, w_acc_next, r_neg, r_rneg);
            else               r_count     <= r_count - 1'b1;
        end
    end

    assign resp_data = r_resp_data;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: vector table plus flush and reset sequences.
module tb_muldiv_sequencer;
    localparam int unsigned BITS = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1, MUL_BUSY = 0;
`else
    localparam int MUL_LAT = 33, MUL_BUSY = 32;
`endif

    logic        clk = 1'b0;
    logic        rst, req_valid, flush;
    logic [2:0]  req_op;
    logic [31:0] req_a, req_b;
    logic        stall, busy, resp_valid;
    logic [31:0] resp_data;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic [1:0]  kind;   // 0 multiply, 1 iterative divide, 2 special-case divide
    } vec_t;

    vec_t vecs[18];

    always #5 clk = ~clk;

    muldiv_sequencer #(.BITS(BITS)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .flush(flush), .stall(stall),
        .busy(busy), .resp_valid(resp_valid), .resp_data(resp_data)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request in the current cycle and follows it to its response.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp,
                          input int lat, input int exp_busy);
        int          got_cycle = -1;
        int          stall_cnt = 0;
        int          busy_cnt  = 0;
        logic        stall_done = 1'b1;
        logic [31:0] got_data  = '0;
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        for (int cyc = 0; cyc <= 60; cyc++) begin
            @(negedge clk);
            if (resp_valid) begin
                got_cycle  = cyc;
                got_data   = resp_data;
                stall_done = stall;
            end else begin
                stall_cnt += int'(stall);
                busy_cnt  += int'(busy);
            end
            tick();
            if (got_cycle >= 0) break;
        end
        req_valid = 1'b0;
        check({tag, " latency"}, got_cycle, lat);
        check({tag, " data"}, got_data, exp);
        check({tag, " stall cycles"}, stall_cnt, lat);
        check({tag, " stall in DONE"}, {31'd0, stall_done}, 32'd0);
        check({tag, " busy cycles"}, busy_cnt, exp_busy);
    endtask

    initial begin
        int lat, bsy, seen;

        vecs[0]  = '{op: 3'b000, a: 32'd7,        b: 32'hFFFFFFFD, exp: 32'hFFFFFFEB, kind: 2'd0};
        vecs[1]  = '{op: 3'b001, a: 32'h80000000, b: 32'h80000000, exp: 32'h40000000, kind: 2'd0};
        vecs[2]  = '{op: 3'b011, a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, exp: 32'hFFFFFFFE, kind: 2'd0};
        vecs[3]  = '{op: 3'b010, a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, exp: 32'hFFFFFFFF, kind: 2'd0};
        vecs[4]  = '{op: 3'b100, a: 32'hFFFFFFF9, b: 32'd2,        exp: 32'hFFFFFFFD, kind: 2'd1};
        vecs[5]  = '{op: 3'b110, a: 32'hFFFFFFF9, b: 32'd2,        exp: 32'hFFFFFFFF, kind: 2'd1};
        vecs[6]  = '{op: 3'b101, a: 32'd100,      b: 32'd7,        exp: 32'd14,       kind: 2'd1};
        vecs[7]  = '{op: 3'b111, a: 32'd100,      b: 32'd7,        exp: 32'd2,        kind: 2'd1};
        vecs[8]  = '{op: 3'b100, a: 32'd7,        b: 32'hFFFFFFFE, exp: 32'hFFFFFFFD, kind: 2'd1};
        vecs[9]  = '{op: 3'b110, a: 32'd7,        b: 32'hFFFFFFFE, exp: 32'd1,        kind: 2'd1};
        vecs[10] = '{op: 3'b101, a: 32'hFFFFFFFF, b: 32'd1,        exp: 32'hFFFFFFFF, kind: 2'd1};
        vecs[11] = '{op: 3'b000, a: 32'h00012345, b: 32'h00010000, exp: 32'h23450000, kind: 2'd0};
        vecs[12] = '{op: 3'b100, a: 32'd5,        b: 32'd0,        exp: 32'hFFFFFFFF, kind: 2'd2};
        vecs[13] = '{op: 3'b111, a: 32'd5,        b: 32'd0,        exp: 32'd5,        kind: 2'd2};
        vecs[14] = '{op: 3'b100, a: 32'h80000000, b: 32'hFFFFFFFF, exp: 32'h80000000, kind: 2'd2};
        vecs[15] = '{op: 3'b110, a: 32'h80000000, b: 32'hFFFFFFFF, exp: 32'd0,        kind: 2'd2};
        vecs[16] = '{op: 3'b101, a: 32'd9,        b: 32'd0,        exp: 32'hFFFFFFFF, kind: 2'd2};
        vecs[17] = '{op: 3'b110, a: 32'hFFFFFFF5, b: 32'd0,        exp: 32'hFFFFFFF5, kind: 2'd2};

        rst = 1'b1; req_valid = 1'b0; flush = 1'b0;
        req_op = 3'b000; req_a = '0; req_b = '0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("reset resp_data", resp_data, 32'd0);
        check("reset flags", {29'd0, stall, busy, resp_valid}, 32'd0);
        tick();

        // Chained back to back: each request appears in the cycle right after the previous DONE.
        for (int i = 0; i < 18; i++) begin
            lat = (vecs[i].kind == 2'd0) ? MUL_LAT : (vecs[i].kind == 2'd1) ? 33 : 1;
            bsy = (vecs[i].kind == 2'd0) ? MUL_BUSY : (vecs[i].kind == 2'd1) ? 32 : 0;
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, lat, bsy);
        end

        // Flush in CALC cycle 10 of a DIVU.
        tick();
        req_valid = 1'b1; req_op = 3'b101; req_a = 32'd1000; req_b = 32'd3;
        repeat (10) tick();
        flush = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        check("flush busy before", {31'd0, busy}, 32'd1);
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("flush after state", {29'd0, stall, busy, resp_valid}, 32'd0);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            @(negedge clk);
            seen += int'(resp_valid);
        end
        check("flush no response", seen, 0);
        tick();
        run_op("post-flush MUL", 3'b000, 32'd3, 32'd4, 32'd12, MUL_LAT, MUL_BUSY);

        // Reset in CALC cycle 5 of a DIV.
        req_valid = 1'b1; req_op = 3'b100; req_a = 32'd100; req_b = 32'd7;
        repeat (4) tick();
        @(negedge clk);
        check("resp_data hold", resp_data, 32'd12);
        check("busy in CALC", {31'd0, busy}, 32'd1);
        tick();
        rst = 1'b1; req_valid = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst resp_data", resp_data, 32'd0);
        check("rst flags", {29'd0, stall, busy, resp_valid}, 32'd0);
        tick();
        run_op("post-reset DIV", 3'b100, 32'd100, 32'd7, 32'd14, 33, 32);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
